// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch pipeline: FSM encoding, NOP word,
// instruction/PC widths and the {instr, pc4} entry carried between fetch and decode.
package mips_pkg;

    localparam int unsigned INSTR_W  = 32;
    localparam logic [31:0] PC_INC   = 32'd4;
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_BUF  = 2'd2;
    localparam logic [1:0] S_KILL = 2'd3;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [31:0]        pc4;
    } fetch_entry_t;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// One-entry skid buffer holding an {instr, pc4} pair fetched while decode was stalled.
module fetch_buf
    import mips_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         drain,
    input  logic         clear,
    input  fetch_entry_t wr_entry,
    output fetch_entry_t rd_entry,
    output logic         full
);

    fetch_entry_t entry_r;
    logic         full_r;

    // Entry storage; clear wins over load, load wins over drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_r <= '{instr: 32'h0000_0000, pc4: 32'h0000_0000};
            full_r  <= 1'b0;
        end else if (clear) begin
            entry_r <= entry_r;
            full_r  <= 1'b0;
        end else if (load) begin
            entry_r <= wr_entry;
            full_r  <= 1'b1;
        end else if (drain) begin
            entry_r <= entry_r;
            full_r  <= 1'b0;
        end else begin
            entry_r <= entry_r;
            full_r  <= full_r;
        end
    end

    assign rd_entry = entry_r;
    assign full     = full_r;

endmodule

// File: rtl/fetch_ifid.sv
// Instruction fetch FSM, PC and IF/ID pipeline register feeding decode.
// Optional FETCH_PERF_CNT_EN adds fetch and stall event counters.
module fetch_ifid
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] CFDE,
    output logic [31:0] PC4_De,
    output logic        valid_De
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_o,
    output logic [31:0] perf_stall_o
`endif
);

    logic [1:0]   state_r, state_nxt_s;
    logic [31:0]  pc_r, pc_nxt_s, pc_inc_s, addr_r;
    logic         req_r, ack_s;
    logic [31:0]  cfde_r, pc4_r;
    logic         valid_r;
    logic         ifid_ld_s, ifid_buf_s;
    logic         buf_load_s, buf_drain_s, buf_clear_s, buf_full_s;
    fetch_entry_t buf_wr_s, buf_rd_s;

    // Acks are only meaningful while a request is on the bus.
    assign ack_s    = imem_ack_i & req_r;
    assign pc_inc_s = pc_r + PC_INC;
    assign buf_wr_s = '{instr: imem_rdata_i, pc4: pc_inc_s};

    // Next-state, next-PC and IF/ID / buffer load decisions; redirect overrides everything.
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = pc_r;
        ifid_ld_s   = 1'b0;
        ifid_buf_s  = 1'b0;
        buf_load_s  = 1'b0;
        buf_drain_s = 1'b0;
        buf_clear_s = flush_i;
        if (redirect_i) begin
            pc_nxt_s    = align_pc(redirect_pc_i);
            buf_clear_s = 1'b1;
            if (req_r && !imem_ack_i) begin
                state_nxt_s = S_KILL;
            end else begin
                state_nxt_s = S_WAIT;
            end
        end else begin
            case (state_r)
                S_IDLE: state_nxt_s = S_WAIT;
                S_WAIT: begin
                    if (ack_s) begin
                        pc_nxt_s = pc_inc_s;
                        if (flush_i) begin
                            state_nxt_s = S_WAIT;
                        end else if (stall_i) begin
                            buf_load_s  = 1'b1;
                            state_nxt_s = S_BUF;
                        end else begin
                            ifid_ld_s = 1'b1;
                        end
                    end else begin
                        state_nxt_s = S_WAIT;
                    end
                end
                S_BUF: begin
                    if (flush_i) begin
                        state_nxt_s = S_WAIT;
                    end else if (!stall_i) begin
                        ifid_buf_s  = buf_full_s;
                        buf_drain_s = 1'b1;
                        state_nxt_s = S_WAIT;
                    end else begin
                        state_nxt_s = S_BUF;
                    end
                end
                S_KILL: begin
                    if (ack_s) begin
                        state_nxt_s = S_WAIT;
                    end else begin
                        state_nxt_s = S_KILL;
                    end
                end
                default: state_nxt_s = S_IDLE;
            endcase
        end
    end

    // FSM state, PC and the bus request; the address is frozen while a killed request drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
            pc_r    <= RESET_PC;
            addr_r  <= RESET_PC;
            req_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            pc_r    <= pc_nxt_s;
            req_r   <= (state_nxt_s == S_WAIT) || (state_nxt_s == S_KILL);
            if (state_nxt_s != S_KILL) begin
                addr_r <= pc_nxt_s;
            end else begin
                addr_r <= addr_r;
            end
        end
    end

    // IF/ID register: flush beats stall, stall holds, otherwise load or insert a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfde_r  <= NOP_INSTR;
            pc4_r   <= 32'h0000_0000;
            valid_r <= 1'b0;
        end else if (flush_i) begin
            cfde_r  <= NOP_INSTR;
            pc4_r   <= pc4_r;
            valid_r <= 1'b0;
        end else if (ifid_ld_s) begin
            cfde_r  <= imem_rdata_i;
            pc4_r   <= pc_inc_s;
            valid_r <= 1'b1;
        end else if (ifid_buf_s) begin
            cfde_r  <= buf_rd_s.instr;
            pc4_r   <= buf_rd_s.pc4;
            valid_r <= 1'b1;
        end else if (stall_i) begin
            cfde_r  <= cfde_r;
            pc4_r   <= pc4_r;
            valid_r <= valid_r;
        end else begin
            cfde_r  <= NOP_INSTR;
            pc4_r   <= pc4_r;
            valid_r <= 1'b0;
        end
    end

    fetch_buf u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (buf_load_s),
        .drain    (buf_drain_s),
        .clear    (buf_clear_s),
        .wr_entry (buf_wr_s),
        .rd_entry (buf_rd_s),
        .full     (buf_full_s)
    );

    assign imem_req_o  = req_r;
    assign imem_addr_o = addr_r;
    assign CFDE        = cfde_r;
    assign PC4_De      = pc4_r;
    assign valid_De    = valid_r;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_r, perf_stall_r;

    // Event counters: valid IF/ID writes and stalled cycles with a live instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_r <= 32'h0000_0000;
            perf_stall_r <= 32'h0000_0000;
        end else begin
            if (ifid_ld_s || ifid_buf_s) begin
                perf_fetch_r <= perf_fetch_r + 32'd1;
            end else begin
                perf_fetch_r <= perf_fetch_r;
            end
            if (stall_i && valid_r) begin
                perf_stall_r <= perf_stall_r + 32'd1;
            end else begin
                perf_stall_r <= perf_stall_r;
            end
        end
    end

    assign perf_fetch_o = perf_fetch_r;
    assign perf_stall_o = perf_stall_r;
`endif

endmodule

// File: tb/tb_fetch_ifid.sv
// Self-checking bench for fetch_ifid: directed scenarios plus a randomized run
// checked against a stream-level model of the fetch/decode interface.
module tb_fetch_ifid;

    logic        clk = 1'b0;
    logic        rst_n, stall, flush, redirect;
    logic [31:0] redirect_pc;
    logic        req, ack;
    logic [31:0] addr, rdata, cfde, pc4;
    logic        valid;
    logic        req_w, ack_w, valid_w;
    logic [31:0] addr_w, rdata_w, cfde_w, pc4_w;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch, perf_stall, perf_fetch_w, perf_stall_w;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int wait_cnt, ack_delay;
    bit rand_delay, force_ack, ack_given, req_neg;

    always #5 clk = ~clk;

    function automatic logic [31:0] memw(input logic [31:0] a);
        return a ^ 32'hC3C3_0F0F;
    endfunction

    assign ack_w   = req_w;
    assign rdata_w = memw(addr_w);

    fetch_ifid dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall), .flush_i(flush),
        .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .imem_req_o(req), .imem_addr_o(addr), .imem_ack_i(ack), .imem_rdata_i(rdata),
        .CFDE(cfde), .PC4_De(pc4), .valid_De(valid)
`ifdef FETCH_PERF_CNT_EN
        , .perf_fetch_o(perf_fetch), .perf_stall_o(perf_stall)
`endif
    );

    fetch_ifid #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
        .clk(clk), .rst_n(rst_n), .stall_i(stall), .flush_i(flush),
        .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .imem_req_o(req_w), .imem_addr_o(addr_w), .imem_ack_i(ack_w), .imem_rdata_i(rdata_w),
        .CFDE(cfde_w), .PC4_De(pc4_w), .valid_De(valid_w)
`ifdef FETCH_PERF_CNT_EN
        , .perf_fetch_o(perf_fetch_w), .perf_stall_o(perf_stall_w)
`endif
    );

    // One clock: memory responds at the falling edge, outputs settle 1 after the rising edge.
    task automatic tick();
        @(negedge clk);
        req_neg = (req === 1'b1);
        if (force_ack || (req_neg && wait_cnt >= ack_delay)) begin
            ack   = 1'b1;
            rdata = force_ack ? 32'hDEAD_BEEF : memw(addr);
        end else begin
            ack   = 1'b0;
            rdata = $urandom;
        end
        ack_given = ack && req_neg;
        @(posedge clk);
        #1;
        if (ack_given || force_ack) begin
            wait_cnt = 0;
            if (rand_delay) ack_delay = $urandom_range(0, 3);
        end else if (req_neg) begin
            wait_cnt++;
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        force_ack = 1'b0; rand_delay = 1'b0; wait_cnt = 0; ack_delay = 0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; redirect = 1'b0;
        tick();
        n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL reset_req actual=%b required=0", req); end
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid actual=%b required=0", valid); end
        n_checks++; if (cfde !== 32'h0) begin n_fail++; $display("FAIL reset_cfde actual=%h required=0", cfde); end
        n_checks++; if (pc4 !== 32'h0) begin n_fail++; $display("FAIL reset_pc4 actual=%h required=0", pc4); end
        n_checks++; if (req_w !== 1'b0) begin n_fail++; $display("FAIL reset_req_w actual=%b required=0", req_w); end
    endtask

    task automatic test_same_cycle();
        logic [31:0] a;
        apply_reset();
        tick();
        n_checks++; if (req !== 1'b1 || addr !== 32'h0) begin n_fail++; $display("FAIL sc_first_req actual=%b/%h required=1/0", req, addr); end
        for (int k = 0; k < 6; k++) begin
            a = 32'(k * 4);
            tick();
            n_checks++; if (cfde !== memw(a) || valid !== 1'b1) begin n_fail++; $display("FAIL sc_cfde k=%0d actual=%h/%b required=%h/1", k, cfde, valid, memw(a)); end
            n_checks++; if (pc4 !== a + 32'd4) begin n_fail++; $display("FAIL sc_pc4 k=%0d actual=%h required=%h", k, pc4, a + 32'd4); end
            n_checks++; if (addr !== a + 32'd4) begin n_fail++; $display("FAIL sc_addr k=%0d actual=%h required=%h", k, addr, a + 32'd4); end
        end
    endtask

    task automatic test_ack_delay();
        apply_reset();
        ack_delay = 3;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (req !== 1'b1 || addr !== 32'h0) begin n_fail++; $display("FAIL dly_addr i=%0d actual=%b/%h required=1/0", i, req, addr); end
            n_checks++; if (cfde !== 32'h0 || valid !== 1'b0) begin n_fail++; $display("FAIL dly_cfde i=%0d actual=%h/%b required=0/0", i, cfde, valid); end
        end
        tick();
        n_checks++; if (cfde !== memw(32'h0) || pc4 !== 32'd4 || valid !== 1'b1) begin n_fail++; $display("FAIL dly_deliver actual=%h/%h/%b required=%h/4/1", cfde, pc4, valid, memw(32'h0)); end
    endtask

    task automatic test_stall_buffer();
        apply_reset();
        tick();
        tick();
        ack_delay = 1; stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++; if (cfde !== memw(32'h0) || pc4 !== 32'd4 || valid !== 1'b1) begin n_fail++; $display("FAIL stall_hold i=%0d actual=%h/%h/%b", i, cfde, pc4, valid); end
            n_checks++; if (req !== (i == 0)) begin n_fail++; $display("FAIL stall_req i=%0d actual=%b required=%b", i, req, (i == 0)); end
        end
        stall = 1'b0; ack_delay = 0;
        tick();
        n_checks++; if (cfde !== memw(32'd4) || pc4 !== 32'd8 || valid !== 1'b1) begin n_fail++; $display("FAIL stall_drain actual=%h/%h/%b required=%h/8/1", cfde, pc4, valid, memw(32'd4)); end
        n_checks++; if (req !== 1'b1 || addr !== 32'd8) begin n_fail++; $display("FAIL stall_resume_addr actual=%b/%h required=1/8", req, addr); end
        tick();
        n_checks++; if (cfde !== memw(32'd8) || pc4 !== 32'd12) begin n_fail++; $display("FAIL stall_next actual=%h/%h required=%h/c", cfde, pc4, memw(32'd8)); end
    endtask

    task automatic test_redirect_kill();
        apply_reset();
        tick();
        tick();
        ack_delay = 2; redirect = 1'b1; redirect_pc = 32'h0000_0103;
        tick();
        redirect = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_checks++; if (req !== 1'b1 || addr !== 32'd4) begin n_fail++; $display("FAIL kill_addr i=%0d actual=%b/%h required=1/4", i, req, addr); end
            tick();
        end
        n_checks++; if (addr !== 32'h100 || valid !== 1'b0) begin n_fail++; $display("FAIL kill_discard actual=%h/%b required=100/0", addr, valid); end
        ack_delay = 0;
        tick();
        n_checks++; if (cfde !== memw(32'h100) || pc4 !== 32'h104) begin n_fail++; $display("FAIL kill_target actual=%h/%h required=%h/104", cfde, pc4, memw(32'h100)); end
    endtask

    task automatic test_flush_redirect();
        apply_reset();
        tick();
        tick();
        stall = 1'b1; flush = 1'b1;
        tick();
        n_checks++; if (cfde !== 32'h0 || valid !== 1'b0) begin n_fail++; $display("FAIL flush_stall actual=%h/%b required=0/0", cfde, valid); end
        stall = 1'b0; flush = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0200;
        tick();
        redirect = 1'b0;
        n_checks++; if (valid !== 1'b0 || cfde !== 32'h0 || addr !== 32'h200) begin n_fail++; $display("FAIL redir_ack_drop actual=%h/%b/%h required=0/0/200", cfde, valid, addr); end
        tick();
        n_checks++; if (cfde !== memw(32'h200) || pc4 !== 32'h204) begin n_fail++; $display("FAIL redir_ack_next actual=%h/%h required=%h/204", cfde, pc4, memw(32'h200)); end
    endtask

    task automatic test_wrap_reset();
        logic [31:0] b;
        apply_reset();
        tick();
        n_checks++; if (addr_w !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL wrap_first actual=%h required=fffffff8", addr_w); end
        for (int k = 0; k < 3; k++) begin
            b = 32'hFFFF_FFF8 + 32'(k * 4);
            tick();
            n_checks++; if (addr_w !== b + 32'd4 || pc4_w !== b + 32'd4 || cfde_w !== memw(b)) begin n_fail++; $display("FAIL wrap k=%0d actual=%h/%h/%h required=%h/%h/%h", k, addr_w, pc4_w, cfde_w, b + 32'd4, b + 32'd4, memw(b)); end
        end
        apply_reset();
        tick();
        tick();
        ack_delay = 5;
        tick();
        rst_n = 1'b0;
        #1;
        n_checks++; if (req !== 1'b0 || valid !== 1'b0 || cfde !== 32'h0 || pc4 !== 32'h0) begin n_fail++; $display("FAIL midreq_reset actual=%b/%b/%h/%h", req, valid, cfde, pc4); end
        force_ack = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        force_ack = 1'b0; ack_delay = 0;
        n_checks++; if (valid !== 1'b0 || cfde !== 32'h0 || req !== 1'b1 || addr !== 32'h0) begin n_fail++; $display("FAIL late_ack actual=%b/%h/%b/%h required=0/0/1/0", valid, cfde, req, addr); end
        tick();
        n_checks++; if (cfde !== memw(32'h0) || pc4 !== 32'd4) begin n_fail++; $display("FAIL after_reset_fetch actual=%h/%h required=%h/4", cfde, pc4, memw(32'h0)); end
    endtask

    task automatic test_random();
        logic [31:0] exp_next, cfde_p, pc4_p, addr_p;
        logic        valid_p, req_p;
        int          deliveries = 0;
        int          exp_stall  = 0;
        apply_reset();
        rand_delay = 1'b1; ack_delay = $urandom_range(0, 3); exp_next = 32'd4;
        for (int c = 0; c < 3000; c++) begin
            stall       = ($urandom_range(0, 3) == 0);
            redirect    = ($urandom_range(0, 19) == 0);
            flush       = redirect && ($urandom_range(0, 3) != 0);
            redirect_pc = $urandom;
            cfde_p = cfde; pc4_p = pc4; valid_p = valid; req_p = req; addr_p = addr;
            if (stall && valid) exp_stall++;
            tick();
            if (flush) begin
                n_checks++; if (valid !== 1'b0 || cfde !== 32'h0) begin n_fail++; $display("FAIL rnd_flush c=%0d actual=%b/%h", c, valid, cfde); end
            end else if (stall) begin
                n_checks++; if (cfde !== cfde_p || pc4 !== pc4_p || valid !== valid_p) begin n_fail++; $display("FAIL rnd_hold c=%0d actual=%h/%h/%b required=%h/%h/%b", c, cfde, pc4, valid, cfde_p, pc4_p, valid_p); end
            end else if (valid) begin
                deliveries++;
                n_checks++; if (pc4 !== exp_next) begin n_fail++; $display("FAIL rnd_order c=%0d actual=%h required=%h", c, pc4, exp_next); end
                exp_next = pc4 + 32'd4;
            end
            if (valid === 1'b1) begin
                n_checks++; if (cfde !== memw(pc4 - 32'd4)) begin n_fail++; $display("FAIL rnd_word c=%0d actual=%h required=%h", c, cfde, memw(pc4 - 32'd4)); end
            end
            if (req_p && !ack_given) begin
                n_checks++; if (req !== 1'b1 || addr !== addr_p) begin n_fail++; $display("FAIL rnd_addr_stable c=%0d actual=%b/%h required=1/%h", c, req, addr, addr_p); end
            end
            if (redirect) exp_next = {redirect_pc[31:2], 2'b00} + 32'd4;
        end
        stall = 1'b0; flush = 1'b0; redirect = 1'b0; rand_delay = 1'b0;
        n_checks++; if (deliveries < 200) begin n_fail++; $display("FAIL rnd_progress actual=%0d required>=200", deliveries); end
`ifdef FETCH_PERF_CNT_EN
        n_checks++; if (perf_fetch !== 32'(deliveries)) begin n_fail++; $display("FAIL perf_fetch actual=%0d required=%0d", perf_fetch, deliveries); end
        n_checks++; if (perf_stall !== 32'(exp_stall)) begin n_fail++; $display("FAIL perf_stall actual=%0d required=%0d", perf_stall, exp_stall); end
`endif
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        ack = 1'b0; rdata = 32'h0; force_ack = 1'b0; rand_delay = 1'b0;
        ack_delay = 0; wait_cnt = 0; ack_given = 1'b0; req_neg = 1'b0;
        test_reset();
        test_same_cycle();
        test_ack_delay();
        test_stall_buffer();
        test_redirect_kill();
        test_flush_redirect();
        test_wrap_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
